// File: rtl/fix_checksum_checker.sv
// FIX checksum checker: forwards the raw byte stream with one cycle of latency,
// finds message boundaries, sums bytes from the leading '8' through the
// delimiter before "10=", decodes the three ASCII digits of tag 10 and flags
// each message as good or bad. Flags line up with data_o of the causing byte.
module fix_checksum_checker #(
  parameter int MAX_MSG_LEN = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_i,
  input  logic             data_valid_i,
  output logic [7:0]       data_o,
  output logic             data_valid_o,
  output logic             msg_start_o,
  output logic             msg_ok_o,
  output logic             msg_err_o,
  output logic [1:0]       err_code_o,
  output logic [7:0]       calc_sum_o,
  output logic [9:0]       rx_sum_o,
  output logic [CNT_W-1:0] ok_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  // Length register must hold MAX_MSG_LEN+1 so the overflowing byte is visible.
  localparam int LEN_W = $clog2(MAX_MSG_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_MSG_LEN);

  localparam logic [7:0] CH_DELIM = 8'h7C;
  localparam logic [7:0] CH_8     = 8'h38;
  localparam logic [7:0] CH_1     = 8'h31;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_EQ    = 8'h3D;

  localparam logic [1:0] ERR_MISMATCH = 2'd0;
  localparam logic [1:0] ERR_DIGIT    = 2'd1;
  localparam logic [1:0] ERR_TERM     = 2'd2;
  localparam logic [1:0] ERR_LEN      = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_BODY, S_F1, S_F2, S_F3, S_DIG, S_TERM
  } state_t;

  state_t           state, state_n;
  logic             field_start;
  logic [7:0]       sum, sum_n, sum_add;
  logic [7:0]       snap, snap_n;
  logic [LEN_W-1:0] len, len_n, len_inc;
  logic [9:0]       rx, rx_n;
  logic [1:0]       dcnt, dcnt_n;
  logic             is_digit;
  logic             start_ev, ok_ev, err_ev;
  logic [1:0]       code_ev;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Next-state and event decode for the byte currently on data_i.
  always_comb begin
    state_n  = state;
    sum_n    = sum;
    snap_n   = snap;
    len_n    = len;
    rx_n     = rx;
    dcnt_n   = dcnt;
    start_ev = 1'b0;
    ok_ev    = 1'b0;
    err_ev   = 1'b0;
    code_ev  = ERR_MISMATCH;
    sum_add  = sum + data_i;
    len_inc  = len + 1'b1;
    is_digit = (data_i >= CH_0) && (data_i <= CH_9);
    case (state)
      S_IDLE: begin
        if (data_i == CH_8 && field_start) begin
          state_n  = S_BODY;
          sum_n    = CH_8;
          len_n    = LEN_W'(1);
          start_ev = 1'b1;
        end
      end
      S_BODY, S_F1, S_F2, S_F3: begin
        sum_n = sum_add;
        len_n = len_inc;
        if (len_inc > LEN_MAX) begin
          err_ev  = 1'b1;
          code_ev = ERR_LEN;
          state_n = S_IDLE;
        end else if (data_i == CH_DELIM) begin
          // Every delimiter may be the one before "10=", so remember the sum.
          snap_n  = sum_add;
          state_n = S_F1;
        end else if (state == S_F1 && data_i == CH_1) begin
          state_n = S_F2;
        end else if (state == S_F2 && data_i == CH_0) begin
          state_n = S_F3;
        end else if (state == S_F3 && data_i == CH_EQ) begin
          state_n = S_DIG;
          rx_n    = '0;
          dcnt_n  = '0;
        end else begin
          // Tags such as 100 or 1x fall back into the body.
          state_n = S_BODY;
        end
      end
      S_DIG: begin
        if (is_digit) begin
          rx_n   = (rx << 3) + (rx << 1) + {6'd0, data_i[3:0]};
          dcnt_n = dcnt + 2'd1;
          if (dcnt == 2'd2) state_n = S_TERM;
        end else begin
          err_ev  = 1'b1;
          code_ev = ERR_DIGIT;
          state_n = S_IDLE;
        end
      end
      S_TERM: begin
        state_n = S_IDLE;
        if (data_i == CH_DELIM) begin
          if (rx == {2'b00, snap}) begin
            ok_ev = 1'b1;
          end else begin
            err_ev  = 1'b1;
            code_ev = ERR_MISMATCH;
          end
        end else begin
          err_ev  = 1'b1;
          code_ev = ERR_TERM;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Register the byte stream, parser state, result fields and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      field_start  <= 1'b1;
      sum          <= '0;
      snap         <= '0;
      len          <= '0;
      rx           <= '0;
      dcnt         <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      msg_start_o  <= 1'b0;
      msg_ok_o     <= 1'b0;
      msg_err_o    <= 1'b0;
      err_code_o   <= '0;
      calc_sum_o   <= '0;
      rx_sum_o     <= '0;
      ok_cnt_o     <= '0;
      err_cnt_o    <= '0;
    end else begin
      data_o       <= data_i;
      data_valid_o <= data_valid_i;
      msg_start_o  <= 1'b0;
      msg_ok_o     <= 1'b0;
      msg_err_o    <= 1'b0;
      if (data_valid_i) begin
        state       <= state_n;
        field_start <= (data_i == CH_DELIM);
        sum         <= sum_n;
        snap        <= snap_n;
        len         <= len_n;
        rx          <= rx_n;
        dcnt        <= dcnt_n;
        msg_start_o <= start_ev;
        msg_ok_o    <= ok_ev;
        msg_err_o   <= err_ev;
        if (err_ev) err_code_o <= code_ev;
        if (ok_ev || err_ev) begin
          calc_sum_o <= snap;
          rx_sum_o   <= rx;
        end
        if (ok_ev)  ok_cnt_o  <= sat_inc(ok_cnt_o);
        if (err_ev) err_cnt_o <= sat_inc(err_cnt_o);
      end
    end
  end

endmodule

// File: tb/tb_fix_checksum_checker.sv
// Bench for fix_checksum_checker: a message-level model (byte queue of the
// current message, checksum recomputed by summing the queue) checked against
// the DUT every cycle, plus hand-computed literal expectations. A second
// instance with MAX_MSG_LEN=8 and 2-bit counters covers length overflow and
// counter saturation.
module tb_fix_checksum_checker;

  localparam int MAXL = 1024;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    data_i = 8'h00;
  logic          data_valid_i = 1'b0;

  logic [7:0]    data_o, calc_sum_o;
  logic          data_valid_o, msg_start_o, msg_ok_o, msg_err_o;
  logic [1:0]    err_code_o;
  logic [9:0]    rx_sum_o;
  logic [CW-1:0] ok_cnt_o, err_cnt_o;

  logic [7:0]    data_o8, calc_sum_o8;
  logic          data_valid_o8, msg_start_o8, msg_ok_o8, msg_err_o8;
  logic [1:0]    err_code_o8;
  logic [9:0]    rx_sum_o8;
  logic [1:0]    ok_cnt_o8, err_cnt_o8;

  fix_checksum_checker #(.MAX_MSG_LEN(MAXL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .data_valid_i(data_valid_i),
    .data_o(data_o), .data_valid_o(data_valid_o), .msg_start_o(msg_start_o),
    .msg_ok_o(msg_ok_o), .msg_err_o(msg_err_o), .err_code_o(err_code_o),
    .calc_sum_o(calc_sum_o), .rx_sum_o(rx_sum_o),
    .ok_cnt_o(ok_cnt_o), .err_cnt_o(err_cnt_o)
  );

  fix_checksum_checker #(.MAX_MSG_LEN(8), .CNT_W(2)) dut8 (
    .clk(clk), .rst(rst), .data_i(data_i), .data_valid_i(data_valid_i),
    .data_o(data_o8), .data_valid_o(data_valid_o8), .msg_start_o(msg_start_o8),
    .msg_ok_o(msg_ok_o8), .msg_err_o(msg_err_o8), .err_code_o(err_code_o8),
    .calc_sum_o(calc_sum_o8), .rx_sum_o(rx_sum_o8),
    .ok_cnt_o(ok_cnt_o8), .err_cnt_o(err_cnt_o8)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 hunting for '8', 1 inside message, 2 reading digits, 3 want '|'
  logic [7:0] msg[$];
  int         mode = 0;
  int         nd = 0;
  bit         fs = 1'b1;
  logic [7:0] snap_m = 8'h00;
  int         rx_m = 0;

  logic [7:0] e_data = 8'h00;
  bit         e_dv = 1'b0, e_start = 1'b0, e_ok = 1'b0, e_err = 1'b0;
  logic [1:0] e_code = 2'd0;
  logic [7:0] e_calc = 8'h00;
  int         e_rx = 0, e_okc = 0, e_errc = 0;

  task automatic post(input bit good, input logic [1:0] code);
    if (good) begin
      e_ok = 1'b1;
      if (e_okc < (2 ** CW) - 1) e_okc++;
    end else begin
      e_err  = 1'b1;
      e_code = code;
      if (e_errc < (2 ** CW) - 1) e_errc++;
    end
    e_calc = snap_m;
    e_rx   = rx_m;
    mode   = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int n;
    int s;
    case (mode)
      0: if (b == 8'h38 && fs) begin
        msg.delete();
        msg.push_back(b);
        mode    = 1;
        e_start = 1'b1;
      end
      1: begin
        msg.push_back(b);
        n = msg.size();
        if (n > MAXL) begin
          post(1'b0, 2'd3);
        end else begin
          if (b == 8'h7C) begin
            s = 0;
            foreach (msg[i]) s += int'(msg[i]);
            snap_m = s[7:0];
          end
          if (n >= 4 && msg[n-4] == 8'h7C && msg[n-3] == 8'h31 &&
              msg[n-2] == 8'h30 && msg[n-1] == 8'h3D) begin
            mode = 2;
            nd   = 0;
            rx_m = 0;
          end
        end
      end
      2: begin
        if (b >= 8'h30 && b <= 8'h39) begin
          rx_m = rx_m * 10 + (int'(b) - 48);
          nd++;
          if (nd == 3) mode = 3;
        end else begin
          post(1'b0, 2'd1);
        end
      end
      default: begin
        if (b == 8'h7C) begin
          if (rx_m == int'(snap_m)) post(1'b1, 2'd0);
          else                      post(1'b0, 2'd0);
        end else begin
          post(1'b0, 2'd2);
        end
      end
    endcase
  endtask

  always @(posedge clk) begin
    if (rst) begin
      msg.delete();
      mode = 0; nd = 0; fs = 1'b1; snap_m = 8'h00; rx_m = 0;
      e_data = 8'h00; e_dv = 1'b0; e_start = 1'b0; e_ok = 1'b0; e_err = 1'b0;
      e_code = 2'd0; e_calc = 8'h00; e_rx = 0; e_okc = 0; e_errc = 0;
    end else begin
      e_data  = data_i;
      e_dv    = data_valid_i;
      e_start = 1'b0;
      e_ok    = 1'b0;
      e_err   = 1'b0;
      if (data_valid_i) begin
        model_byte(data_i);
        fs = (data_i == 8'h7C);
      end
    end
  end

  // Compare the main DUT with the model on the falling edge of every cycle.
  always @(negedge clk) begin
    chk("data_o", data_o, e_data);
    chk("data_valid_o", data_valid_o, e_dv);
    chk("msg_start_o", msg_start_o, e_start);
    chk("msg_ok_o", msg_ok_o, e_ok);
    chk("msg_err_o", msg_err_o, e_err);
    if (e_err) chk("err_code_o", err_code_o, e_code);
    chk("calc_sum_o", calc_sum_o, e_calc);
    chk("rx_sum_o", rx_sum_o, e_rx);
    chk("ok_cnt_o", ok_cnt_o, e_okc);
    chk("err_cnt_o", err_cnt_o, e_errc);
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b, input bit v);
    @(negedge clk);
    data_i       = b;
    data_valid_i = v;
    @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s, input bit gap);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], 1'b1);
      if (gap) send(8'h00, 1'b0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data_o"}, data_o, 0);
    chk({tag, "_dv"}, data_valid_o, 0);
    chk({tag, "_start"}, msg_start_o, 0);
    chk({tag, "_ok"}, msg_ok_o, 0);
    chk({tag, "_err"}, msg_err_o, 0);
    chk({tag, "_code"}, err_code_o, 0);
    chk({tag, "_calc"}, calc_sum_o, 0);
    chk({tag, "_rx"}, rx_sum_o, 0);
    chk({tag, "_okc"}, ok_cnt_o, 0);
    chk({tag, "_errc"}, err_cnt_o, 0);
    chk({tag, "8_data_o"}, data_o8, 0);
    chk({tag, "8_dv"}, data_valid_o8, 0);
    chk({tag, "8_start"}, msg_start_o8, 0);
    chk({tag, "8_ok"}, msg_ok_o8, 0);
    chk({tag, "8_err"}, msg_err_o8, 0);
    chk({tag, "8_code"}, err_code_o8, 0);
    chk({tag, "8_calc"}, calc_sum_o8, 0);
    chk({tag, "8_rx"}, rx_sum_o8, 0);
    chk({tag, "8_okc"}, ok_cnt_o8, 0);
    chk({tag, "8_errc"}, err_cnt_o8, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    data_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // "8=A|" sums to 306 -> 50
    send(8'h7C, 1'b1);
    send(8'h38, 1'b1);
    chk("t1_start", msg_start_o, 1);
    send_str("=A|10=050|", 1'b0);
    chk("t1_ok", msg_ok_o, 1);
    chk("t1_err", msg_err_o, 0);
    chk("t1_calc", calc_sum_o, 50);
    chk("t1_rx", rx_sum_o, 50);
    chk("t1_okc", ok_cnt_o, 1);

    // Checksum mismatch
    send_str("|8=A|10=051|", 1'b0);
    chk("t2_err", msg_err_o, 1);
    chk("t2_code", err_code_o, 0);
    chk("t2_calc", calc_sum_o, 50);
    chk("t2_rx", rx_sum_o, 51);
    chk("t2_errc", err_cnt_o, 1);
    chk("t2_okc", ok_cnt_o, 1);

    // Bad digit, then resynchronise
    send_str("|8=A|10=0X", 1'b0);
    chk("t3_err", msg_err_o, 1);
    chk("t3_code", err_code_o, 1);
    chk("t3_errc", err_cnt_o, 2);
    send_str("0|8=A|10=050|", 1'b0);
    chk("t3_ok", msg_ok_o, 1);
    chk("t3_okc", ok_cnt_o, 2);

    // Tag 100 is not the checksum; "8=A|100=1|" sums to 685 -> 173
    send_str("|8=A|100=1|10=173|", 1'b0);
    chk("t4_ok", msg_ok_o, 1);
    chk("t4_calc", calc_sum_o, 173);
    chk("t4_okc", ok_cnt_o, 3);

    // Missing terminator after three digits
    send_str("|8=A|10=0500", 1'b0);
    chk("t5_err", msg_err_o, 1);
    chk("t5_code", err_code_o, 2);
    chk("t5_rx", rx_sum_o, 50);
    send(8'h7C, 1'b1);

    // Repeated delimiter refreshes the snapshot: "8=A||" sums to 430 -> 174
    send_str("|8=A||10=174|", 1'b0);
    chk("t6_ok", msg_ok_o, 1);
    chk("t6_calc", calc_sum_o, 174);
    chk("t6_okc", ok_cnt_o, 4);

    // Valid toggled every other cycle
    send_str("|8=A|10=050", 1'b1);
    send(8'h7C, 1'b1);
    chk("t7_ok", msg_ok_o, 1);
    chk("t7_dv", data_valid_o, 1);
    chk("t7_okc", ok_cnt_o, 5);
    send(8'h00, 1'b0);
    chk("t7_ok_gap", msg_ok_o, 0);
    chk("t7_dv_gap", data_valid_o, 0);

    // Length overflow on the 1025th byte of the main instance
    send_str("|8", 1'b0);
    for (int i = 0; i < MAXL - 1; i++) send(8'h41, 1'b1);
    chk("t8_no_err", msg_err_o, 0);
    send(8'h41, 1'b1);
    chk("t8_err", msg_err_o, 1);
    chk("t8_code", err_code_o, 3);
    chk("t8_errc", err_cnt_o, 4);
    send(8'h7C, 1'b1);

    // MAX_MSG_LEN=8 instance: overflow on the 9th byte
    @(negedge clk);
    rst = 1'b1;
    data_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    send_str("8=AAAAAA", 1'b0);
    chk("t9_no_err8", msg_err_o8, 0);
    send(8'h41, 1'b1);
    chk("t9_err8", msg_err_o8, 1);
    chk("t9_code8", err_code_o8, 3);
    chk("t9_errc8", err_cnt_o8, 1);
    chk("t9_main_err", msg_err_o, 0);
    send_str("AA|", 1'b0);
    // Three more overflows saturate the 2-bit counter
    send_str("8=AAAAAAA|8=AAAAAAA|8=AAAAAAA|", 1'b0);
    chk("t9_errc8_sat", err_cnt_o8, 3);

    // Reset mid-message clears everything next cycle
    send_str("8=AA", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    data_i = 8'h41;
    data_valid_i = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    data_valid_i = 1'b0;
    send_str("8=A|10=050|", 1'b0);
    chk("t10_ok", msg_ok_o, 1);
    chk("t10_okc", ok_cnt_o, 1);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
